// File: rtl/sp_ram_pkg.sv
// Shared defaults and helpers for the sp_ram_rw32 data memory.
// No logic; constants, the read-source encoding and the index-width helper.
// No flow control.
package sp_ram_pkg;

  localparam int SP_RAM_DATA_WIDTH = 32;
  localparam int SP_RAM_ADDR_WIDTH = 32;
  localparam int SP_RAM_DEPTH      = 256;

  // Where the registered read result currently comes from.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_ARRAY  = 2'd1,
    SRC_BYPASS = 2'd2
  } rd_src_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Plain storage array: one synchronous write port, one synchronous read port.
// Read latency 1 cycle; rd_data holds while rd_en is low. No reset.
// No backpressure: a port enable is acted on every cycle it is high.
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = SP_RAM_DATA_WIDTH,
  parameter int DEPTH      = SP_RAM_DEPTH,
  parameter int IDX_WIDTH  = idx_width(SP_RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/sp_ram_rw32.sv
// Single-port word RAM, write-first on same-edge read/write; optional bounds check (SP_RAM_RW_BOUNDS_CHECK_EN).
// Read and write latency 1 cycle; data_out holds while re is low; sync active-low reset clears data_out.
// No backpressure: every asserted re/we is accepted at full rate.
module sp_ram_rw32
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = SP_RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SP_RAM_ADDR_WIDTH,
  parameter int DEPTH      = SP_RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  re,
  input  logic                  we
`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
  ,
  output logic                  addr_err
`endif
);

  localparam int IW = idx_width(DEPTH);

  logic [IW-1:0]         idx;
  logic                  in_range;
  logic                  arr_wr_en;
  logic                  arr_rd_en;
  logic [DATA_WIDTH-1:0] arr_rd_data;
  logic [DATA_WIDTH-1:0] byp_q;
  rd_src_e               sel_q;

  assign idx = address[IW-1:0];

`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
  assign in_range = ((address >> IW) == '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^address;
  assign in_range       = 1'b1;
`endif

  // The array only reads when the result can't come from the bypass or zero path.
  assign arr_wr_en = rst_n & we & in_range;
  assign arr_rd_en = rst_n & re & ~we & in_range;

  sp_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IW)
  ) u_array (
    .clk     (clk),
    .idx     (idx),
    .wr_en   (arr_wr_en),
    .wr_data (data_in),
    .rd_en   (arr_rd_en),
    .rd_data (arr_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= SRC_ZERO;
    end else if (re) begin
      if (!in_range) begin
        sel_q <= SRC_ZERO;
      end else if (we) begin
        sel_q <= SRC_BYPASS;
      end else begin
        sel_q <= SRC_ARRAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && re && we) begin
      byp_q <= data_in;
    end
  end

`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if (re || we) begin
      addr_err <= ~in_range;
    end
  end
`endif

  always_comb begin
    data_out = '0;
    case (sel_q)
      SRC_ARRAY:  data_out = arr_rd_data;
      SRC_BYPASS: data_out = byp_q;
      default:    data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_sp_ram_rw32.sv
// Randomized + directed bench for sp_ram_rw32 against an array-based reference model.
module tb_sp_ram_rw32;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          re = 1'b0;
  logic          we = 1'b0;
`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
  logic          addr_err;
`endif

  sp_ram_rw32 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .re       (re),
    .we       (we)
`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
    ,
    .addr_err (addr_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          known;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: memory contents plus a "has been written" mask.
  logic [DW-1:0] mem_m [DEPTH];
  bit            mem_k [DEPTH];
  logic [DW-1:0] m_d     = '0;
  bit            m_known = 1'b0;
  bit            m_err   = 1'b0;

  function automatic void model(input bit r, input bit rd, input bit wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned i;
    bit          ok;
    i  = int'(a % DEPTH);
`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
    ok = (a < DEPTH);
`else
    ok = 1'b1;
`endif
    if (!r) begin
      m_d = '0; m_known = 1'b1; m_err = 1'b0;
    end else begin
      if (rd || wr) m_err = !ok;
      if (rd) begin
        if (!ok)     begin m_d = '0;       m_known = 1'b1;     end
        else if (wr) begin m_d = d;        m_known = 1'b1;     end
        else         begin m_d = mem_m[i]; m_known = mem_k[i]; end
      end
      if (wr && ok) begin mem_m[i] = d; mem_k[i] = 1'b1; end
    end
  endfunction

  task automatic cyc(input bit r, input bit rd, input bit wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    rst_n = r; re = rd; we = wr; address = a; data_in = d;
    model(r, rd, wr, a, d);
    e.d = m_d; e.known = m_known; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per edge, compared shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.known) begin
          checks++;
          if (data_out !== e.d) begin
            fails++;
            $display("FAIL data_out @%0t: got %h expected %h", $time, data_out, e.d);
          end
        end
`ifdef SP_RAM_RW_BOUNDS_CHECK_EN
        checks++;
        if (addr_err !== e.err) begin
          fails++;
          $display("FAIL addr_err @%0t: got %b expected %b", $time, addr_err, e.err);
        end
`endif
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    int            r;
    for (int i = 0; i < DEPTH; i++) mem_k[i] = 1'b0;

    // Reset, write 111 to 1, read it back.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 9, 32'h1234);
    cyc(1, 0, 1, 1, 111);
    cyc(1, 1, 0, 1, 0);
    // Same-edge read/write returns the new data.
    cyc(1, 1, 1, 5, 32'hDEADBEEF);
    // Hold: read 1, then re low for 3 cycles with a changing address.
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 0, 7, 0);
    cyc(1, 0, 0, 7, 0);
    cyc(1, 0, 0, 7, 0);
    // Reset suppresses writes.
    cyc(1, 0, 1, 3, 77);
    cyc(0, 0, 1, 3, 42);
    cyc(1, 1, 0, 3, 0);
    // Both ends of the array, no aliasing.
    cyc(1, 0, 1, 0, 32'hAAAA_0000);
    cyc(1, 0, 1, DEPTH - 1, 32'h0000_5555);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, DEPTH - 1, 0);
    // Out-of-range / wrapping address.
    cyc(1, 0, 1, DEPTH, 9);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, DEPTH, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, DEPTH - 1, 0);

    // Randomized traffic with occasional resets and far addresses.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1023);
      else                           a = $urandom_range(0, DEPTH - 1);
      cyc((r < 3) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a, $urandom);
    end
    cyc(1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
